motion_vector_decoder: RTL and testbench

MOTION_VECTOR_DECODER -- requirements
Module: motion_vector_decoder

---
 rtl/mpeg_mv_pkg.sv | 26 ++
 rtl/mv_vlc_lookup.sv | 45 ++++
 rtl/motion_vector_decoder.sv | 159 +++++++++++++++
 tb/tb_motion_vector_decoder.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpeg_mv_pkg.sv
// Shared types and constants for the MPEG motion vector decoder.
// FSM encoding, VLC code lengths and default widths.
package mpeg_mv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    RECON,
    OUT
  } state_t;

  localparam int DEF_MAX_FCODE = 9;
  localparam int DEF_MV_W      = 13;
  localparam int VLC_BITS      = 11;
  localparam int MC_MAX        = 16;

  // Full code length per |motion_code|, sign bit included
  localparam logic [3:0] VLC_LEN [MC_MAX+1] = '{
    4'd1,  4'd3,  4'd4,  4'd5,
    4'd7,  4'd8,  4'd8,  4'd8,
    4'd10, 4'd10, 4'd10,
    4'd11, 4'd11, 4'd11,
    4'd11, 4'd11, 4'd11
  };

endpackage

// File: rtl/mv_vlc_lookup.sv
// Combinational motion_code VLC lookup.
// Looks at the next 11 window bits and returns value, sign and length.
module mv_vlc_lookup
  import mpeg_mv_pkg::*;
(
  input  logic [VLC_BITS-1:0] bits,
  output logic                valid,
  output logic [4:0]          value,
  output logic                sign,
  output logic [3:0]          length
);

  logic [3:0] sign_pos;

  always_comb begin
    valid = 1'b1;
    value = 5'd0;
    unique casez (bits)
      11'b1??????????: value = 5'd0;
      11'b01?????????: value = 5'd1;
      11'b001????????: value = 5'd2;
      11'b0001???????: value = 5'd3;
      11'b000011?????: value = 5'd4;
      11'b0000101????: value = 5'd5;
      11'b0000100????: value = 5'd6;
      11'b0000011????: value = 5'd7;
      11'b000001011??: value = 5'd8;
      11'b000001010??: value = 5'd9;
      11'b000001001??: value = 5'd10;
      11'b0000010001?: value = 5'd11;
      11'b0000010000?: value = 5'd12;
      11'b0000001111?: value = 5'd13;
      11'b0000001110?: value = 5'd14;
      11'b0000001101?: value = 5'd15;
      11'b0000001100?: value = 5'd16;
      default:         valid = 1'b0;
    endcase
  end

  assign length   = valid ? VLC_LEN[value] : 4'd0;
  // Sign is the last bit of the code; code 0 carries none
  assign sign_pos = 4'd11 - length;
  assign sign     = valid && (value != 5'd0) && bits[sign_pos];

endmodule

// File: rtl/motion_vector_decoder.sv
// MPEG motion vector decoder: VLC + residual parse,
// predictor reconstruction with range wrap, valid/ready output.
module motion_vector_decoder
  import mpeg_mv_pkg::*;
#(
  parameter int NUM_COMP  = 2,
  parameter int MAX_FCODE = DEF_MAX_FCODE,
  parameter int MV_W      = DEF_MV_W,
  parameter int BUF_W     = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [3:0]               f_code,
  input  logic                     pmv_clear,
  input  logic [BUF_W-1:0]         buf_data,
  input  logic                     buf_valid,
  output logic [4:0]               shift,
  output logic                     shift_valid,
  output logic [NUM_COMP*MV_W-1:0] mv_out,
  output logic                     mv_valid,
  input  logic                     mv_ready,
  output logic                     busy,
  output logic                     error
);

  localparam int KW = (NUM_COMP > 1) ? $clog2(NUM_COMP) : 1;
  localparam int XW = MV_W + 3;
  localparam logic [KW-1:0] KLAST = KW'(NUM_COMP - 1);
  localparam logic [3:0] MAXF = 4'(MAX_FCODE);

  state_t state;
  logic [3:0] r_size;
  logic [KW-1:0] k;
  logic [4:0] mc;
  logic mc_neg;
  logic [7:0] res;
  logic signed [MV_W-1:0] pmv [NUM_COMP];

  logic vlc_valid;
  logic [4:0] vlc_value;
  logic vlc_sign;
  logic [3:0] vlc_len;

  mv_vlc_lookup u_vlc (
    .bits   (buf_data[BUF_W-1 -: VLC_BITS]),
    .valid  (vlc_valid),
    .value  (vlc_value),
    .sign   (vlc_sign),
    .length (vlc_len)
  );

  logic has_res;
  logic dec_ok;
  logic [BUF_W-1:0] after_vlc;
  logic [7:0] top8;
  logic [7:0] res_val;

  assign has_res   = (r_size != 4'd0) && (vlc_value != 5'd0);
  assign dec_ok    = (state == DECODE) && buf_valid && vlc_valid;
  assign after_vlc = buf_data << vlc_len;
  assign top8      = after_vlc[BUF_W-1 -: 8];
  assign res_val   = top8 >> (4'd8 - r_size);

  assign shift_valid = dec_ok;
  assign shift = dec_ok
    ? 5'(vlc_len) + (has_res ? 5'(r_size) : 5'd0)
    : 5'd0;
  assign busy = (state != IDLE);

  logic [XW-1:0] mag;
  logic signed [XW-1:0] delta, pred, v, lim, span, vw;
  logic signed [MV_W-1:0] new_mv;

  always_comb begin
    mag   = ((XW'(mc) - XW'(1)) << r_size) + XW'(res) + XW'(1);
    delta = '0;
    if (mc != 5'd0)
      delta = mc_neg ? -$signed(mag) : $signed(mag);
    pred = {{(XW-MV_W){pmv[k][MV_W-1]}}, pmv[k]};
    v    = pred + delta;
    lim  = $signed(XW'(16) << r_size);
    span = lim <<< 1;
    vw   = v;
    if (v > lim - XW'(1))
      vw = v - span;
    else if (v < -lim)
      vw = v + span;
  end

  assign new_mv = vw[MV_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      r_size   <= '0;
      k        <= '0;
      mc       <= '0;
      mc_neg   <= 1'b0;
      res      <= '0;
      mv_out   <= '0;
      mv_valid <= 1'b0;
      error    <= 1'b0;
      for (int i = 0; i < NUM_COMP; i++)
        pmv[i] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pmv_clear)
            for (int i = 0; i < NUM_COMP; i++)
              pmv[i] <= '0;
          if (start) begin
            if (f_code == 4'd0 || f_code > MAXF) begin
              error <= 1'b1;
            end else begin
              error  <= 1'b0;
              r_size <= f_code - 4'd1;
              k      <= '0;
              state  <= DECODE;
            end
          end
        end
        DECODE: begin
          if (buf_valid) begin
            if (vlc_valid) begin
              mc     <= vlc_value;
              mc_neg <= vlc_sign;
              res    <= has_res ? res_val : 8'd0;
              state  <= RECON;
            end else begin
              error <= 1'b1;
              state <= IDLE;
            end
          end
        end
        RECON: begin
          pmv[k] <= new_mv;
          for (int i = 0; i < NUM_COMP; i++)
            if (k == KW'(i))
              mv_out[i*MV_W +: MV_W] <= new_mv;
          if (k == KLAST) begin
            mv_valid <= 1'b1;
            state    <= OUT;
          end else begin
            k     <= k + KW'(1);
            state <= DECODE;
          end
        end
        OUT: begin
          if (mv_ready) begin
            mv_valid <= 1'b0;
            state    <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_motion_vector_decoder.sv
// Scoreboard bench for motion_vector_decoder with an
// upstream bitstream model and an integer reference model.
module tb_motion_vector_decoder;

  localparam int NC = 2;
  localparam int MW = 13;
  localparam int BW = 20;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [3:0] f_code;
  logic pmv_clear;
  logic [BW-1:0] buf_data;
  logic buf_valid;
  logic [4:0] shift;
  logic shift_valid;
  logic [NC*MW-1:0] mv_out;
  logic mv_valid;
  logic mv_ready;
  logic busy;
  logic error;

  always #5 clk = ~clk;

  motion_vector_decoder dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .f_code      (f_code),
    .pmv_clear   (pmv_clear),
    .buf_data    (buf_data),
    .buf_valid   (buf_valid),
    .shift       (shift),
    .shift_valid (shift_valid),
    .mv_out      (mv_out),
    .mv_valid    (mv_valid),
    .mv_ready    (mv_ready),
    .busy        (busy),
    .error       (error)
  );

  int checks = 0;
  int errors = 0;
  int exp_shift_q[$];
  logic [NC*MW-1:0] exp_mv_q[$];
  int mpmv[NC];

  bit strm[512];
  int slen = 0;
  int pos = 0;
  bit act = 0;
  bit stall_en = 0;
  bit manual_ready = 0;
  bit sv_s = 0;
  bit st_s = 0;
  int sh_s = 0;

  // Code bits without sign, and their lengths, per |motion_code|
  int vcode[17] = '{1, 1, 1, 1, 3, 5, 4, 3, 11, 10, 9,
                    17, 16, 15, 14, 13, 12};
  int vlen[17] = '{1, 2, 3, 4, 6, 7, 7, 7, 9, 9, 9,
                   10, 10, 10, 10, 10, 10};

  task automatic chk(string name, longint av, longint ev);
    checks++;
    if (av != ev) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               name, av, av, ev, ev);
    end
  endtask

  always @(negedge clk) begin
    sv_s = shift_valid;
    sh_s = int'(shift);
    st_s = start && !busy;
    if (rst) begin
      if (shift_valid) begin
        if (exp_shift_q.size() == 0)
          chk("spurious shift_valid", shift_valid, 0);
        else
          chk("shift", shift, exp_shift_q.pop_front());
      end
      if (mv_valid && mv_ready) begin
        if (exp_mv_q.size() == 0)
          chk("spurious mv_valid", mv_valid, 0);
        else
          chk("mv_out", mv_out, exp_mv_q.pop_front());
      end
    end
  end

  // Upstream: consume on shift_valid, hold buf_valid low next cycle
  always @(posedge clk) begin
    #1;
    if (st_s)
      pos = 0;
    else if (sv_s)
      pos += sh_s;
    buf_valid = !sv_s && act &&
                (!stall_en || $urandom_range(0, 3) != 0);
    for (int i = 0; i < BW; i++)
      buf_data[BW-1-i] = (pos + i < slen) ? strm[pos+i] : 1'b0;
    if (!manual_ready)
      mv_ready = ($urandom_range(0, 2) != 0);
  end

  task automatic put(int val, int n);
    for (int i = n - 1; i >= 0; i--) begin
      strm[slen] = val[i];
      slen++;
    end
  endtask

  task automatic issue(int fc, int mc0, int r0,
                       int mc1, int r1, bit clr);
    int mcs[2];
    int rs[2];
    int rsz, f, am, d, v, sh, reff;
    logic [NC*MW-1:0] e;
    mcs = '{mc0, mc1};
    rs = '{r0, r1};
    rsz = fc - 1;
    f = 1 << rsz;
    slen = 0;
    e = '0;
    if (clr)
      for (int k = 0; k < NC; k++) mpmv[k] = 0;
    for (int k = 0; k < NC; k++) begin
      am = (mcs[k] < 0) ? -mcs[k] : mcs[k];
      put(vcode[am], vlen[am]);
      sh = vlen[am];
      reff = 0;
      if (am != 0) begin
        put(int'(mcs[k] < 0), 1);
        sh++;
      end
      if (am != 0 && rsz > 0) begin
        put(rs[k], rsz);
        sh += rsz;
        reff = rs[k];
      end
      d = (am == 0) ? 0 : (am - 1) * f + reff + 1;
      if (mcs[k] < 0) d = -d;
      v = mpmv[k] + d;
      if (v > 16 * f - 1) v -= 32 * f;
      else if (v < -16 * f) v += 32 * f;
      mpmv[k] = v;
      e[k*MW +: MW] = MW'(v);
      exp_shift_q.push_back(sh);
    end
    exp_mv_q.push_back(e);
    act = 1;
    f_code = 4'(fc);
    pmv_clear = clr;
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
    pmv_clear = 0;
  endtask

  task automatic wait_idle(string name);
    int n;
    n = 0;
    while ((busy || exp_mv_q.size() != 0) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: busy=%0b pending=%0d, expected idle",
               name, busy, exp_mv_q.size());
      exp_mv_q.delete();
      exp_shift_q.delete();
    end
    act = 0;
  endtask

  task automatic bad_start(int fc);
    f_code = 4'(fc);
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
  endtask

  initial begin
    int lat, n, fc, rmax;
    logic [NC*MW-1:0] snap;
    rst = 0;
    start = 0;
    f_code = 0;
    pmv_clear = 0;
    buf_valid = 0;
    buf_data = '0;
    mv_ready = 0;
    for (int k = 0; k < NC; k++) mpmv[k] = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", busy, 0);
    chk("reset error", error, 0);
    chk("reset mv_valid", mv_valid, 0);
    chk("reset shift_valid", shift_valid, 0);
    chk("reset mv_out", mv_out, 0);
    rst = 1;
    @(posedge clk);
    #1;

    issue(1, 0, 0, 0, 0, 0);
    wait_idle("zero code");
    chk("zero code comp0", $signed(mv_out[MW-1:0]), 0);

    issue(1, 1, 0, -1, 0, 0);
    lat = 1;
    while (!mv_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, 5);
    wait_idle("plus minus one");
    chk("pm1 comp1", $signed(mv_out[2*MW-1:MW]), -1);

    issue(2, 2, 1, 0, 0, 1);
    wait_idle("residual");
    chk("residual comp0", $signed(mv_out[MW-1:0]), 4);

    issue(1, 15, 0, 0, 0, 1);
    wait_idle("wrap setup");
    issue(1, 3, 0, 0, 0, 0);
    wait_idle("wrap");
    chk("wrap comp0", $signed(mv_out[MW-1:0]), -14);

    slen = 0;
    put(1, 10);
    act = 1;
    bad_start(1);
    n = 0;
    while (busy && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    act = 0;
    chk("vlc error flag", error, 1);
    chk("vlc error idle", busy, 0);
    issue(1, 0, 0, 2, 0, 0);
    chk("error cleared", error, 0);
    wait_idle("after error");

    bad_start(0);
    chk("fcode0 error", error, 1);
    chk("fcode0 idle", busy, 0);
    issue(9, -16, 255, 16, 0, 0);
    chk("fcode9 legal", error, 0);
    wait_idle("fcode9");
    bad_start(10);
    chk("fcode10 error", error, 1);
    chk("fcode10 idle", busy, 0);

    manual_ready = 1;
    mv_ready = 0;
    issue(3, 5, 2, -7, 3, 0);
    n = 0;
    while (!mv_valid && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("stall reached out", mv_valid, 1);
    snap = mv_out;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        f_code = 4'd1;
        start = 1;
      end
      @(posedge clk);
      #1;
      start = 0;
      chk("stall valid", mv_valid, 1);
      chk("stall data", mv_out, snap);
      chk("stall busy", busy, 1);
    end
    mv_ready = 1;
    manual_ready = 0;
    wait_idle("stall");

    stall_en = 1;
    for (int t = 0; t < 40; t++) begin
      int m0, m1, q0, q1;
      fc = int'($urandom_range(1, 9));
      rmax = (1 << (fc - 1)) - 1;
      m0 = int'($urandom_range(0, 32)) - 16;
      m1 = int'($urandom_range(0, 32)) - 16;
      q0 = int'($urandom_range(0, rmax));
      q1 = int'($urandom_range(0, rmax));
      issue(fc, m0, q0, m1, q1, $urandom_range(0, 7) == 0);
      wait_idle("random");
    end
    stall_en = 0;

    issue(1, 4, 0, -3, 0, 0);
    wait_idle("pre reset");
    slen = 0;
    put(1, 1);
    act = 0;
    bad_start(1);
    chk("busy before reset", busy, 1);
    #2;
    rst = 0;
    #1;
    chk("midreset busy", busy, 0);
    chk("midreset mv_valid", mv_valid, 0);
    chk("midreset shift_valid", shift_valid, 0);
    chk("midreset shift", shift, 0);
    chk("midreset error", error, 0);
    chk("midreset mv_out", mv_out, 0);
    exp_mv_q.delete();
    exp_shift_q.delete();
    for (int k = 0; k < NC; k++) mpmv[k] = 0;
    @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk);
    #1;
    issue(1, 1, 0, 0, 0, 0);
    wait_idle("post reset");
    chk("post reset comp1", $signed(mv_out[2*MW-1:MW]), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
